data_selector: RTL and testbench
================================

# data_selector

Registered 8-to-1 single-bit data selector. It drives `out` from the bit of `in` addressed by `sel`. The select input is resynchronised on chip because it comes from board switches. The block sits between the rotating one-hot pattern register and the LED/output pin in the 8:1 selector lab top level, with `in` driven by the rotating pattern and `sel` by user switches.

## Interface
Parameters:
- `N_IN`, default 8: number of data inputs; must be a power of two.
- `SEL_W`, default 3: select width; must equal log2(`N_IN`).

Ports:
- `clk`  input  1: single system clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `in`  input  `N_IN` (8): data inputs, bit i is data channel i. Synchronous to `clk`.
- `sel`  input  `SEL_W` (3): channel address, unsigned binary. Asynchronous to `clk` (switch input).
- `out`  output  1: selected data bit, registered.

## Operation
- Channel mapping: `sel` = k selects `in[k]`, so 3'd0 selects `in[0]` and 3'd7 selects `in[7]`. No inversion, no bit reversal.
- `sel` synchroniser: two-flop chain `sel_s1` <- `sel`, `sel_s2` <- `sel_s1`, applied per bit. Only `sel_s2` addresses the mux.
- Mux: combinational `in[sel_s2]`. It is sampled into the `out` register every rising `clk` edge.
- No enable, no hold: `out` updates every cycle.
- Every value of `SEL_W` bits is a legal address. No out-of-range case exists for power-of-two `N_IN`.
- Reset (`rst_n` = 0), asynchronous:
  - `sel_s1` = `sel_s2` = 0, so channel 0 is selected after reset.
  - `out` = 0, even if `in[0]` = 1.
  - The values hold while `rst_n` is low, regardless of `clk`.
- Reset release: the first rising edge with `rst_n` = 1 loads `out` <- `in[0]` and `sel_s1` <- `sel`.
- Reset mid-operation: `out` and the synchroniser clear immediately on the `rst_n` falling edge, without waiting for a clock edge. Operation restarts from the released state above.
- Multi-bit `sel` changes can land in the synchroniser skewed by one cycle. `out` may then show one intermediate channel for one cycle. This is permitted and must settle on the new channel by the latency stated in Timing.

## Timing
- Data path latency: a change on `in[k]` with `sel_s2` = k appears on `out` 1 clock later, at the next rising edge.
- Select path latency: a `sel` change that meets setup before edge E appears as:
  - `sel_s1` after E
  - `sel_s2` after E+1
  - `out` showing the new channel after E+2, i.e. 3 rising edges counted from E inclusive.
- Steady state: with `sel` stable, `out(t+1)` = `in[sel](t)`.
- Output is glitch-free: `out` changes only on `clk` rising edges or asynchronously on reset assertion.
- Top-level context: the pattern register rotates much more slowly than `clk`. With a one-hot rotating `in`, `out` is high for exactly one rotation step in every 8, delayed by 1 `clk`.

## Test plan
- Reset:
  - Hold `rst_n` = 0 with `in` = 8'hFF, `sel` = 3'd5 for 5 clocks -> `out` = 0 throughout.
  - Release -> `out` = 1 from the first edge (`in[0]`). `in[5]` is followed from the 3rd edge.
- Full address sweep:
  - `in` = 8'b1010_0110, step `sel` 0..7, holding each value 4 clocks.
  - Settled `out` sequence -> 0,1,1,0,0,1,0,1.
- Select latency:
  - `in` = 8'h01, `sel` 0 -> 1 just before edge E.
  - `out` = 1 after E and E+1, then 0 from E+2.
- Data latency:
  - `sel` = 3'd7 settled, `in` toggles 8'h00 -> 8'h80 before edge E -> `out` rises exactly after E.
- Rotating one-hot:
  - `in` starts at 8'h01 and rotates left every 10 clocks; `sel` = 3'd3.
  - `out` is high only for the 10-clock window where `in` = 8'h08, offset by 1 clock.
  - The window repeats every 80 clocks.
- Async reset mid-stream:
  - With `out` = 1, assert `rst_n` low between edges -> `out` is 0 immediately, without waiting for a clock edge.
  - Release -> behaviour matches the Reset scenario.

Source files
------------

// File: rtl/data_selector.sv
// Registered N:1 single-bit selector. The select comes from board switches and is
// resynchronised through a two-flop chain before it addresses the mux.
module data_selector #(
    parameter int N_IN  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in,
    input  logic [SEL_W-1:0] sel,
    output logic             out
);

    logic [SEL_W-1:0] sel_s1;
    logic [SEL_W-1:0] sel_s2;
    logic             mux_bit;

    // Only the second synchroniser stage may address the mux; sel_s1 can be metastable.
    assign mux_bit = in[sel_s2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1 <= '0;
            sel_s2 <= '0;
            out    <= 1'b0;
        end else begin
            sel_s1 <= sel;
            sel_s2 <= sel_s1;
            out    <= mux_bit;
        end
    end

endmodule

// File: tb/tb_data_selector.sv
// Self-checking bench for data_selector: directed scenarios plus random traffic,
// compared against a history-based model of the select and data latencies.
module tb_data_selector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_r;
    logic [2:0] sel_r;
    logic       out;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] in_hist[$];
    logic [2:0] sel_hist[$];

    data_selector #(.N_IN(8), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_r),
        .sel   (sel_r),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output after the n-th edge since release: data sampled at edge n, channel
    // taken from the select sampled two edges earlier (channel 0 before that).
    function automatic logic model_out();
        int         n;
        logic [7:0] d;
        logic [2:0] k;
        n = in_hist.size();
        d = in_hist[n-1];
        k = (n >= 3) ? sel_hist[n-3] : 3'd0;
        return d[k];
    endfunction

    task automatic tick(input string tag);
        logic exp;
        if (rst_n) begin
            in_hist.push_back(in_r);
            sel_hist.push_back(sel_r);
        end
        @(posedge clk);
        #1;
        exp = rst_n ? model_out() : 1'b0;
        check({31'd0, out}, {31'd0, exp}, tag);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        in_hist.delete();
        sel_hist.delete();
        #1;
        check({31'd0, out}, 32'd0, "reset_async");
    endtask

    initial begin
        int         high_cnt;
        logic [7:0] sweep;
        rst_n = 1'b0;
        in_r  = 8'hFF;
        sel_r = 3'd5;

        // Reset held with all inputs high
        for (int i = 0; i < 5; i++) tick("reset_hold");
        rst_n = 1'b1;
        tick("release_e1");
        check({31'd0, out}, 32'd1, "release_in0");
        tick("release_e2");
        in_r = 8'h20;
        tick("release_e3");
        check({31'd0, out}, 32'd1, "release_in5");
        tick("release_e4");

        // Full address sweep
        sweep = 8'b1010_0110;
        in_r  = sweep;
        for (int k = 0; k < 8; k++) begin
            sel_r = 3'(k);
            for (int c = 0; c < 4; c++) tick("sweep");
            check({31'd0, out}, {31'd0, sweep[k]}, "sweep_settled");
        end

        // Select latency
        in_r  = 8'h01;
        sel_r = 3'd0;
        for (int i = 0; i < 4; i++) tick("sel_lat_pre");
        sel_r = 3'd1;
        tick("sel_lat_e");
        check({31'd0, out}, 32'd1, "sel_lat_e");
        tick("sel_lat_e1");
        check({31'd0, out}, 32'd1, "sel_lat_e1");
        tick("sel_lat_e2");
        check({31'd0, out}, 32'd0, "sel_lat_e2");

        // Data latency
        sel_r = 3'd7;
        in_r  = 8'h00;
        for (int i = 0; i < 4; i++) tick("data_lat_pre");
        check({31'd0, out}, 32'd0, "data_lat_pre");
        in_r = 8'h80;
        tick("data_lat_e");
        check({31'd0, out}, 32'd1, "data_lat_e");

        // Rotating one-hot pattern, two full rotations
        sel_r    = 3'd3;
        in_r     = 8'h01;
        high_cnt = 0;
        for (int i = 0; i < 160; i++) begin
            tick("rotate");
            if (i >= 2 && out === 1'b1) high_cnt++;
            if (i % 10 == 9) in_r = {in_r[6:0], in_r[7]};
        end
        check(32'(high_cnt), 32'd20, "rotate_high_cycles");

        // Async reset mid-stream with out high
        in_r  = 8'hFF;
        sel_r = 3'd2;
        for (int i = 0; i < 4; i++) tick("mid_pre");
        check({31'd0, out}, 32'd1, "mid_out_high");
        #3;
        assert_reset();
        in_r  = 8'hFF;
        sel_r = 3'd5;
        for (int i = 0; i < 3; i++) tick("mid_hold");
        rst_n = 1'b1;
        tick("mid_release_e1");
        tick("mid_release_e2");
        in_r = 8'h20;
        tick("mid_release_e3");
        check({31'd0, out}, 32'd1, "mid_release_in5");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_r = 8'($urandom);
            if ($urandom_range(3, 0) == 0) sel_r = 3'($urandom);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
